regfile_writeback_arbiter: RTL and testbench
============================================

// Module: regfile_writeback_arbiter
// PURPOSE
//   Write-side client of the 64-entry register file. Merges completed results from two producers
//   (ALU and memory-load unit) into the single register-file write port (writereg_addr/write_data/RegWrite).
//   Buffers each producer in its own FIFO and arbitrates one write per cycle with a starvation guard.
//   Sits between the execute/memory stages and the register file; busy lets the decoder stall.
// PARAMETERS
//   DataLength  64  width of result data and of write_data
//   AddrWidth   6   register address width (64 registers)
//   FifoDepth   4   entries per source FIFO; power of 2, >= 2
//   DropZero    0   1: entries addressed to register 0 are consumed without asserting RegWrite
// PORTS
//   clk            in   1           clock, all state updates on rising edge
//   rst            in   1           reset, asynchronous, active-high
//   alu_valid      in   1           ALU result present
//   alu_ready      out  1           ALU FIFO can accept
//   alu_addr       in   AddrWidth   ALU destination register
//   alu_data       in   DataLength  ALU result
//   mem_valid      in   1           load result present
//   mem_ready      out  1           load FIFO can accept
//   mem_addr       in   AddrWidth   load destination register
//   mem_data       in   DataLength  load result
//   writereg_addr  out  AddrWidth   register-file write address (registered)
//   write_data     out  DataLength  register-file write data (registered)
//   RegWrite       out  1           register-file write enable (registered)
//   busy           out  1           any FIFO non-empty or RegWrite high
// BEHAVIOUR
//   - Reset (async, immediate): both FIFOs empty, pointers/counts 0, starve_cnt 0, RegWrite 0,
//     writereg_addr 0, write_data 0. alu_ready/mem_ready = 0 while rst high. Mid-operation reset discards all pending entries.
//   - Push: entry captured at an edge where x_valid && x_ready. x_ready = !rst && count_x < FifoDepth,
//     from registered count only: full FIFO stays not-ready even when popping that cycle (no pass-through).
//   - Push and pop on the same FIFO in one cycle: count unchanged, both take effect.
//   - Arbitration, at most one pop per edge:
//       only one FIFO non-empty -> pop it;
//       both non-empty -> mem wins, unless starve_cnt == 3, then ALU wins;
//       starve_cnt increments (saturating at 3) when ALU non-empty and loses; clears when ALU pops or ALU FIFO empty.
//   - On a pop at edge k: writereg_addr/write_data load the head entry. RegWrite = 1 for the cycle after edge k,
//     except 0 when DropZero=1 and addr==0. With no pop, RegWrite = 0 and addr/data hold their last values.
//   - Latency: entry accepted at edge k into an empty, uncontended FIFO is popped at edge k+1. The register file writes it at edge k+2.
//   - Ordering: per-source FIFO order preserved. Cross-source order is set by arbitration only.
//     Upstream owns WAW hazards between sources.
//   - Pointers wrap modulo FifoDepth. count width = log2(FifoDepth)+1.
//   - busy = (count_alu != 0) || (count_mem != 0) || RegWrite.
// TESTING
//   1 Reset: assert rst mid-stream with 3 entries queued -> RegWrite 0 at once, ready 0 during rst; after release ready=1, busy=0, no writes appear.
//   2 Single ALU push addr=5 data=0xDEAD at edge k -> RegWrite=1, addr=5, data=0xDEAD in cycle after edge k+1, one cycle only.
//   3 Fill ALU FIFO with 4 pushes and no pops possible (hold mem busy) -> alu_ready=0 after 4th; 5th valid not accepted; all 4 drain in order.
//   4 Both FIFOs kept non-empty continuously -> pattern mem,mem,mem,alu repeating; ALU never waits more than 3 wins.
//   5 DropZero=1: ALU push addr=0 then addr=7 -> no RegWrite for addr 0; RegWrite for addr 7 one cycle later; busy falls after.
//   6 Full mem FIFO, simultaneous pop and mem_valid -> push refused that cycle, accepted next cycle; count sequence 4,3,4.

Source files
------------

// File: rtl/regfile_writeback_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_writeback_arbiter_if
//   Bundles the two producer handshakes (ALU and memory-load results) and the
//   register-file write port of regfile_writeback_arbiter.
//
//   Handshake semantics, for both producers: a producer holds x_valid together
//   with stable x_addr/x_data until it sees x_ready high at a rising clock
//   edge; the entry is transferred exactly at an edge where x_valid && x_ready.
//   x_ready never depends on x_valid.
//
//   Ports / signals:
//     alu_valid, alu_addr, alu_data   producer -> arbiter, ALU result
//     alu_ready                       arbiter -> producer, ALU FIFO can accept
//     mem_valid, mem_addr, mem_data   producer -> arbiter, load result
//     mem_ready                       arbiter -> producer, load FIFO can accept
//     writereg_addr, write_data       register-file write address/data
//     RegWrite                        register-file write enable
//     busy                            work pending (decoder stall hint)
//
//   Modports: master = producers + register file side, slave = the arbiter.
// -----------------------------------------------------------------------------
interface regfile_writeback_arbiter_if #(
    parameter int DataLength = 64,
    parameter int AddrWidth  = 6
);
    logic                  alu_valid;
    logic                  alu_ready;
    logic [AddrWidth-1:0]  alu_addr;
    logic [DataLength-1:0] alu_data;

    logic                  mem_valid;
    logic                  mem_ready;
    logic [AddrWidth-1:0]  mem_addr;
    logic [DataLength-1:0] mem_data;

    logic [AddrWidth-1:0]  writereg_addr;
    logic [DataLength-1:0] write_data;
    logic                  RegWrite;
    logic                  busy;

    modport master (
        output alu_valid, alu_addr, alu_data,
        output mem_valid, mem_addr, mem_data,
        input  alu_ready, mem_ready,
        input  writereg_addr, write_data, RegWrite, busy
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  mem_valid, mem_addr, mem_data,
        output alu_ready, mem_ready,
        output writereg_addr, write_data, RegWrite, busy
    );
endinterface

// File: rtl/regfile_writeback_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_writeback_arbiter
//   Merges completed results from the ALU and the memory-load unit into the
//   single register-file write port. Each producer has its own FIFO; one entry
//   is popped per cycle. Loads win contention, but after the ALU has lost three
//   times in a row it wins the next arbitration (starvation guard).
//
//   Ports:
//     clk   in  clock, rising edge
//     rst   in  asynchronous active-high reset
//     bus   regfile_writeback_arbiter_if.slave (producer handshakes, write port)
//
//   Timing: an entry accepted at edge k into an empty, uncontended FIFO is
//   popped at edge k+1; writereg_addr/write_data/RegWrite are registered, so
//   the register file writes it at edge k+2.
// -----------------------------------------------------------------------------
module regfile_writeback_arbiter #(
    parameter int DataLength = 64,
    parameter int AddrWidth  = 6,
    parameter int FifoDepth  = 4,
    parameter int DropZero   = 0
) (
    input logic                         clk,
    input logic                         rst,
    regfile_writeback_arbiter_if.slave  bus
);
    localparam int             PW        = $clog2(FifoDepth);
    localparam int             CW        = PW + 1;
    localparam logic [CW-1:0]  FULL_CNT  = CW'(FifoDepth);
    localparam bit             DROP_ZERO = (DropZero != 0);
    localparam logic [1:0]     STARVE_MAX = 2'd3;

    // ---------------- ALU FIFO ----------------
    logic [AddrWidth-1:0]  alu_addr_q [FifoDepth];
    logic [DataLength-1:0] alu_data_q [FifoDepth];
    logic [PW-1:0]         alu_wr_ptr, alu_rd_ptr;
    logic [CW-1:0]         alu_cnt;
    logic                  alu_push, alu_pop, alu_ne;

    // ---------------- load FIFO ----------------
    logic [AddrWidth-1:0]  mem_addr_q [FifoDepth];
    logic [DataLength-1:0] mem_data_q [FifoDepth];
    logic [PW-1:0]         mem_wr_ptr, mem_rd_ptr;
    logic [CW-1:0]         mem_cnt;
    logic                  mem_push, mem_pop, mem_ne;

    // ---------------- arbitration / output ----------------
    logic [1:0]            starve_cnt, starve_next;
    logic                  alu_priority;
    logic [AddrWidth-1:0]  sel_addr;
    logic [DataLength-1:0] sel_data;
    logic [AddrWidth-1:0]  wr_addr_r;
    logic [DataLength-1:0] wr_data_r;
    logic                  reg_write_r;

    // Ready comes from the registered count only: a full FIFO refuses a push
    // even in a cycle where it is also being popped.
    assign bus.alu_ready = !rst && (alu_cnt != FULL_CNT);
    assign bus.mem_ready = !rst && (mem_cnt != FULL_CNT);

    assign alu_push = bus.alu_valid && bus.alu_ready;
    assign mem_push = bus.mem_valid && bus.mem_ready;
    assign alu_ne   = (alu_cnt != '0);
    assign mem_ne   = (mem_cnt != '0);

    // ---------------- starvation guard: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= 2'd0;
        end else begin
            starve_cnt <= starve_next;
        end
    end

    // ---------------- starvation guard: next state ----------------
    // Any cycle where the ALU FIFO is non-empty and not popped, the load
    // FIFO was popped instead, i.e. the ALU lost an arbitration.
    always_comb begin
        starve_next = starve_cnt;
        if (alu_pop || !alu_ne) begin
            starve_next = 2'd0;
        end else if (starve_cnt != STARVE_MAX) begin
            starve_next = starve_cnt + 2'd1;
        end
    end

    // ---------------- starvation guard: outputs / pop select ----------------
    always_comb begin
        alu_priority = (starve_cnt == STARVE_MAX);
        alu_pop      = alu_ne && (!mem_ne || alu_priority);
        mem_pop      = mem_ne && !alu_pop;
        sel_addr     = alu_pop ? alu_addr_q[alu_rd_ptr] : mem_addr_q[mem_rd_ptr];
        sel_data     = alu_pop ? alu_data_q[alu_rd_ptr] : mem_data_q[mem_rd_ptr];
    end

    // ---------------- FIFO storage (no reset needed: guarded by counts) ------
    always_ff @(posedge clk) begin
        if (alu_push) begin
            alu_addr_q[alu_wr_ptr] <= bus.alu_addr;
            alu_data_q[alu_wr_ptr] <= bus.alu_data;
        end
        if (mem_push) begin
            mem_addr_q[mem_wr_ptr] <= bus.mem_addr;
            mem_data_q[mem_wr_ptr] <= bus.mem_data;
        end
    end

    // ---------------- FIFO pointers and counts ----------------
    // Pointers wrap naturally because FifoDepth is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_wr_ptr <= '0;
            alu_rd_ptr <= '0;
            alu_cnt    <= '0;
            mem_wr_ptr <= '0;
            mem_rd_ptr <= '0;
            mem_cnt    <= '0;
        end else begin
            if (alu_push) alu_wr_ptr <= alu_wr_ptr + PW'(1);
            if (alu_pop)  alu_rd_ptr <= alu_rd_ptr + PW'(1);
            if (mem_push) mem_wr_ptr <= mem_wr_ptr + PW'(1);
            if (mem_pop)  mem_rd_ptr <= mem_rd_ptr + PW'(1);

            case ({alu_push, alu_pop})
                2'b10:   alu_cnt <= alu_cnt + CW'(1);
                2'b01:   alu_cnt <= alu_cnt - CW'(1);
                default: alu_cnt <= alu_cnt;
            endcase

            case ({mem_push, mem_pop})
                2'b10:   mem_cnt <= mem_cnt + CW'(1);
                2'b01:   mem_cnt <= mem_cnt - CW'(1);
                default: mem_cnt <= mem_cnt;
            endcase
        end
    end

    // ---------------- registered write port ----------------
    // addr/data load on every pop, even a dropped register-0 write; they
    // only hold when nothing is popped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr_r   <= '0;
            wr_data_r   <= '0;
            reg_write_r <= 1'b0;
        end else if (alu_pop || mem_pop) begin
            wr_addr_r   <= sel_addr;
            wr_data_r   <= sel_data;
            reg_write_r <= !(DROP_ZERO && (sel_addr == '0));
        end else begin
            reg_write_r <= 1'b0;
        end
    end

    assign bus.writereg_addr = wr_addr_r;
    assign bus.write_data    = wr_data_r;
    assign bus.RegWrite      = reg_write_r;
    assign bus.busy          = alu_ne || mem_ne || reg_write_r;
endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_writeback_arbiter
//   Self-checking bench for regfile_writeback_arbiter. Entries are pushed to a
//   per-source expected queue when accepted and popped/compared when the DUT
//   writes them. ALU results carry data bit 63 = 0, load results bit 63 = 1,
//   which identifies the source of each write. A second instance with
//   DropZero=1 covers the register-0 drop behaviour.
// -----------------------------------------------------------------------------
module tb_regfile_writeback_arbiter;
    localparam int DL = 64;
    localparam int AW = 6;
    localparam int W  = AW + DL;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_writeback_arbiter_if #(.DataLength(DL), .AddrWidth(AW)) bus ();
    regfile_writeback_arbiter_if #(.DataLength(DL), .AddrWidth(AW)) bus_dz ();

    regfile_writeback_arbiter #(
        .DataLength(DL), .AddrWidth(AW), .FifoDepth(4), .DropZero(0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    regfile_writeback_arbiter #(
        .DataLength(DL), .AddrWidth(AW), .FifoDepth(4), .DropZero(1)
    ) dut_dz (
        .clk (clk),
        .rst (rst),
        .bus (bus_dz)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] exp_alu_q[$];
    logic [W-1:0] exp_mem_q[$];
    int           wr_cnt = 0;
    bit           log_en = 1'b0;
    bit           src_log[$];

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DL-1:0] alu_val(input int i);
        return 64'h0A00_0000_0000_0000 | 64'(i);
    endfunction

    function automatic logic [DL-1:0] mem_val(input int i);
        return 64'hB000_0000_0000_0000 | 64'(i);
    endfunction

    // ---------------- scoreboard: capture accepted entries ----------------
    always @(posedge clk) begin
        if (rst) begin
            exp_alu_q.delete();
            exp_mem_q.delete();
        end else begin
            if (bus.alu_valid && bus.alu_ready) exp_alu_q.push_back({bus.alu_addr, bus.alu_data});
            if (bus.mem_valid && bus.mem_ready) exp_mem_q.push_back({bus.mem_addr, bus.mem_data});
        end
    end

    // ---------------- scoreboard: compare writes ----------------
    always @(negedge clk) begin : wr_mon
        logic [W-1:0] e;
        if (!rst && bus.RegWrite) begin
            wr_cnt++;
            if (bus.write_data[DL-1]) begin
                if (log_en) src_log.push_back(1'b1);
                check_eq("wr_mem_pending", 128'(exp_mem_q.size() != 0), 128'd1);
                if (exp_mem_q.size() != 0) begin
                    e = exp_mem_q.pop_front();
                    check_eq("wr_mem_entry", {bus.writereg_addr, bus.write_data}, e);
                end
            end else begin
                if (log_en) src_log.push_back(1'b0);
                check_eq("wr_alu_pending", 128'(exp_alu_q.size() != 0), 128'd1);
                if (exp_alu_q.size() != 0) begin
                    e = exp_alu_q.pop_front();
                    check_eq("wr_alu_entry", {bus.writereg_addr, bus.write_data}, e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alu_valid    = 1'b0; bus.alu_addr    = '0; bus.alu_data    = '0;
        bus.mem_valid    = 1'b0; bus.mem_addr    = '0; bus.mem_data    = '0;
        bus_dz.alu_valid = 1'b0; bus_dz.alu_addr = '0; bus_dz.alu_data = '0;
        bus_dz.mem_valid = 1'b0; bus_dz.mem_addr = '0; bus_dz.mem_data = '0;
    endtask

    task automatic drain(input string tag, input int max_cyc);
        int c = 0;
        while (bus.busy && c < max_cyc) begin
            tick();
            c++;
        end
        check_eq(tag, 128'(bus.busy), 128'd0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin : main
        int snap;
        bit ar_log[32];
        bit mr_log[32];
        int ai, mi, zeros;
        logic [AW-1:0] a_addr, m_addr;
        bit ar, mr;

        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset state, sampled while rst is still high.
        check_eq("rst_alu_ready", 128'(bus.alu_ready), 128'd0);
        check_eq("rst_mem_ready", 128'(bus.mem_ready), 128'd0);
        check_eq("rst_regwrite",  128'(bus.RegWrite), 128'd0);
        check_eq("rst_addr",      128'(bus.writereg_addr), 128'd0);
        check_eq("rst_data",      128'(bus.write_data), 128'd0);
        check_eq("rst_busy",      128'(bus.busy), 128'd0);
        rst = 1'b0;
        #1;
        check_eq("post_rst_alu_ready", 128'(bus.alu_ready), 128'd1);
        check_eq("post_rst_mem_ready", 128'(bus.mem_ready), 128'd1);

        // ---- 1: reset mid-stream with 3 entries queued ----
        tick();
        bus.alu_valid = 1'b1; bus.alu_addr = 6'd1; bus.alu_data = alu_val(1);
        bus.mem_valid = 1'b1; bus.mem_addr = 6'd2; bus.mem_data = mem_val(1);
        tick();
        bus.alu_addr = 6'd3; bus.alu_data = alu_val(2);
        bus.mem_addr = 6'd4; bus.mem_data = mem_val(2);
        tick();
        idle_inputs();
        check_eq("t1_busy_before", 128'(bus.busy), 128'd1);
        #1 rst = 1'b1;
        #1;
        check_eq("t1_regwrite_now", 128'(bus.RegWrite), 128'd0);
        check_eq("t1_alu_ready_rst", 128'(bus.alu_ready), 128'd0);
        check_eq("t1_mem_ready_rst", 128'(bus.mem_ready), 128'd0);
        check_eq("t1_busy_rst", 128'(bus.busy), 128'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        snap = wr_cnt;
        repeat (5) tick();
        check_eq("t1_no_writes", 128'(wr_cnt - snap), 128'd0);
        check_eq("t1_busy_after", 128'(bus.busy), 128'd0);
        check_eq("t1_alu_ready_after", 128'(bus.alu_ready), 128'd1);

        // ---- 2: single ALU push, latency and one-cycle pulse ----
        bus.alu_valid = 1'b1; bus.alu_addr = 6'd5; bus.alu_data = 64'hDEAD;
        tick();                                   // edge k: accepted
        idle_inputs();
        check_eq("t2_regwrite_k", 128'(bus.RegWrite), 128'd0);
        tick();                                   // edge k+1: popped
        check_eq("t2_regwrite_k1", 128'(bus.RegWrite), 128'd1);
        check_eq("t2_addr", 128'(bus.writereg_addr), 128'd5);
        check_eq("t2_data", 128'(bus.write_data), 128'hDEAD);
        tick();
        check_eq("t2_regwrite_k2", 128'(bus.RegWrite), 128'd0);
        check_eq("t2_addr_hold", 128'(bus.writereg_addr), 128'd5);
        check_eq("t2_busy_idle", 128'(bus.busy), 128'd0);

        // ---- 3: fill ALU FIFO while loads hold the port ----
        snap = wr_cnt;
        for (int c = 1; c <= 5; c++) begin
            bus.alu_valid = 1'b1;
            bus.alu_addr  = AW'(8 + c);
            bus.alu_data  = alu_val(16 + c);
            bus.mem_valid = (c <= 4);
            bus.mem_addr  = AW'(20 + c);
            bus.mem_data  = mem_val(16 + c);
            tick();
            if (c == 4) check_eq("t3_alu_full", 128'(bus.alu_ready), 128'd0);
            if (c == 5) check_eq("t3_alu_ready_again", 128'(bus.alu_ready), 128'd1);
        end
        idle_inputs();
        drain("t3_drain", 40);
        check_eq("t3_write_count", 128'(wr_cnt - snap), 128'd8);

        // ---- 4/6: both sources streaming; arbitration pattern, full refusal ----
        pulse_reset();
        src_log.delete();
        log_en = 1'b1;
        ai = 100;
        mi = 100;
        a_addr = AW'($urandom_range(1, 63));
        m_addr = AW'($urandom_range(1, 63));
        for (int c = 1; c <= 24; c++) begin
            bus.alu_valid = 1'b1; bus.alu_addr = a_addr; bus.alu_data = alu_val(ai);
            bus.mem_valid = 1'b1; bus.mem_addr = m_addr; bus.mem_data = mem_val(mi);
            ar = bus.alu_ready;
            mr = bus.mem_ready;
            tick();
            if (ar) begin ai++; a_addr = AW'($urandom_range(0, 63)); end
            if (mr) begin mi++; m_addr = AW'($urandom_range(0, 63)); end
            ar_log[c] = bus.alu_ready;
            mr_log[c] = bus.mem_ready;
        end
        idle_inputs();
        drain("t4_drain", 60);
        log_en = 1'b0;

        check_eq("t4_alu_full_e4", 128'(ar_log[4]), 128'd0);
        check_eq("t4_alu_ready_e5", 128'(ar_log[5]), 128'd1);
        zeros = 0;
        for (int c = 1; c <= 12; c++) if (!mr_log[c]) zeros++;
        check_eq("t6_mem_ready_early", 128'(zeros), 128'd0);
        check_eq("t6_mem_full_e13", 128'(mr_log[13]), 128'd0);
        check_eq("t6_mem_ready_e14", 128'(mr_log[14]), 128'd1);
        check_eq("t4_log_len", 128'(src_log.size() >= 16), 128'd1);
        for (int i = 0; i < 16 && i < src_log.size(); i++) begin
            check_eq($sformatf("t4_pattern_%0d", i), 128'(src_log[i]), 128'((i % 4) != 3));
        end

        // ---- 5: DropZero instance, register 0 write suppressed ----
        bus_dz.alu_valid = 1'b1; bus_dz.alu_addr = 6'd0; bus_dz.alu_data = 64'h1111;
        tick();                                   // edge k: addr 0 accepted
        bus_dz.alu_addr = 6'd7; bus_dz.alu_data = 64'h7777;
        tick();                                   // edge k+1: addr 0 popped, addr 7 accepted
        idle_inputs();
        check_eq("t5_drop_regwrite", 128'(bus_dz.RegWrite), 128'd0);
        check_eq("t5_drop_busy", 128'(bus_dz.busy), 128'd1);
        tick();
        check_eq("t5_r7_regwrite", 128'(bus_dz.RegWrite), 128'd1);
        check_eq("t5_r7_addr", 128'(bus_dz.writereg_addr), 128'd7);
        check_eq("t5_r7_data", 128'(bus_dz.write_data), 128'h7777);
        tick();
        check_eq("t5_end_regwrite", 128'(bus_dz.RegWrite), 128'd0);
        check_eq("t5_end_busy", 128'(bus_dz.busy), 128'd0);

        // ---- final: nothing left unwritten ----
        repeat (3) tick();
        check_eq("end_alu_q_empty", 128'(exp_alu_q.size()), 128'd0);
        check_eq("end_mem_q_empty", 128'(exp_mem_q.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
